// File: rtl/plam_seq_if.sv
// plam_seq_if: operand/result handshake bundle for the sequential
// posit log-approximate multiplier. The master drives operands and
// accepts results; the slave (plam_seq) does the opposite.
interface plam_seq_if #(
  parameter int SIZE = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] X1;
  logic [SIZE-1:0] X2;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] res;
  logic            exp1;

  modport master (
    output in_valid, X1, X2, out_ready,
    input  in_ready, out_valid, res, exp1
  );

  modport slave (
    input  in_valid, X1, X2, out_ready,
    output in_ready, out_valid, res, exp1
  );
endinterface

// File: rtl/plam_seq.sv
// plam_seq: sequential posit log-approximate multiplier.
// Produces the normalized fraction of (1+f1)(1+f2) and an exponent
// increment flag. The f1*f2 cross term is built from ITER Mitchell
// corrections, one per clock, accumulated in a 2*SIZE-bit register.
// Optional feature: define PLAM_ROUND_EN to round half up on the
// exp1=1 path (saturating at all-ones); undefined gives truncation.
module plam_seq #(
  parameter int SIZE = 16,
  parameter int ITER = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  plam_seq_if.slave    bus
);

  localparam int KW = $clog2(SIZE);
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int PW = 2 * SIZE;
  localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);

  // One-hot encoding so every handshake output is a flop bit.
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_ITER = 4'b0010,
    S_SUM  = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;

  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic [SIZE-1:0] r_x1;
  logic [SIZE-1:0] r_x2;
  logic [PW-1:0]   r_p;
  logic [CW-1:0]   r_cnt;
  logic [SIZE-1:0] r_res;
  logic            r_exp1;

  logic            w_accept;
  logic            w_do_iter;
  logic            w_do_sum;
  logic            w_consume;

  logic [KW-1:0]   w_k1;
  logic [KW-1:0]   w_k2;
  logic [KW:0]     w_ksum;
  logic            w_nz;
  logic [PW-1:0]   w_a_sh;
  logic [PW-1:0]   w_b_sh;
  logic [PW-1:0]   w_pow;
  logic [PW-1:0]   w_term;
  logic [SIZE-1:0] w_a_nx;
  logic [SIZE-1:0] w_b_nx;

  logic [SIZE+1:0] w_s;
  logic [SIZE:0]   w_rnd;
  logic [SIZE-1:0] w_res_nx;
  logic            w_exp1_nx;

  // Leading-one detector: index of the most significant set bit (0 for v==0).
  function automatic logic [KW-1:0] lod(input logic [SIZE-1:0] v);
    logic [KW-1:0] k;
    k = {KW{1'b0}};
    for (int i = 0; i < SIZE; i++) begin
      if (v[i]) begin
        k = KW'(i);
      end else begin
        k = k;
      end
    end
    return k;
  endfunction

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic: fixed ITER-cycle iteration phase, held DONE under backpressure.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_nx = S_ITER;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_ITER: begin
        if (r_cnt == LAST_ITER) begin
          w_state_nx = S_SUM;
        end else begin
          w_state_nx = S_ITER;
        end
      end
      S_SUM: begin
        w_state_nx = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_DONE;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Output/strobe decode from the current state.
  always_comb begin
    w_accept  = 1'b0;
    w_do_iter = 1'b0;
    w_do_sum  = 1'b0;
    w_consume = 1'b0;
    case (r_state)
      S_IDLE:  w_accept  = bus.in_valid;
      S_ITER:  w_do_iter = 1'b1;
      S_SUM:   w_do_sum  = 1'b1;
      S_DONE:  w_consume = bus.out_ready;
      default: w_accept  = 1'b0;
    endcase
  end

  assign bus.in_ready  = r_state[0];
  assign bus.out_valid = r_state[3];
  assign bus.res       = r_res;
  assign bus.exp1      = r_exp1;

  // One Mitchell correction: term = A*B - (A-2^k1)*(B-2^k2), zero once either side is exhausted.
  always_comb begin
    w_k1   = lod(r_a);
    w_k2   = lod(r_b);
    w_nz   = (r_a != {SIZE{1'b0}}) && (r_b != {SIZE{1'b0}});
    w_ksum = {1'b0, w_k1} + {1'b0, w_k2};
    w_a_sh = {{SIZE{1'b0}}, r_a} << w_k2;
    w_b_sh = {{SIZE{1'b0}}, r_b} << w_k1;
    w_pow  = {{(PW-1){1'b0}}, 1'b1} << w_ksum;
    if (w_nz) begin
      w_term = w_a_sh + w_b_sh - w_pow;
      w_a_nx = r_a - ({{(SIZE-1){1'b0}}, 1'b1} << w_k1);
      w_b_nx = r_b - ({{(SIZE-1){1'b0}}, 1'b1} << w_k2);
    end else begin
      w_term = {PW{1'b0}};
      w_a_nx = r_a;
      w_b_nx = r_b;
    end
  end

  // Final sum 1 + f1 + f2 + corr, then normalize into [1,2) with exponent flag.
  always_comb begin
    w_s = {2'b01, {SIZE{1'b0}}}
        + {2'b00, r_x1}
        + {2'b00, r_x2}
        + {2'b00, r_p[PW-1:SIZE]};
    w_rnd = {1'b0, w_s[SIZE:1]} + {{SIZE{1'b0}}, w_s[0]};
    if (w_s[SIZE+1]) begin
      w_exp1_nx = 1'b1;
`ifdef PLAM_ROUND_EN
      if (w_rnd[SIZE]) begin
        w_res_nx = {SIZE{1'b1}};
      end else begin
        w_res_nx = w_rnd[SIZE-1:0];
      end
`else
      w_res_nx = w_s[SIZE:1];
`endif
    end else begin
      w_exp1_nx = 1'b0;
      w_res_nx  = w_s[SIZE-1:0];
    end
  end

  // Operand capture, accumulator and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= {SIZE{1'b0}};
      r_b   <= {SIZE{1'b0}};
      r_x1  <= {SIZE{1'b0}};
      r_x2  <= {SIZE{1'b0}};
      r_p   <= {PW{1'b0}};
      r_cnt <= {CW{1'b0}};
    end else if (w_accept) begin
      r_a   <= bus.X1;
      r_b   <= bus.X2;
      r_x1  <= bus.X1;
      r_x2  <= bus.X2;
      r_p   <= {PW{1'b0}};
      r_cnt <= {CW{1'b0}};
    end else if (w_do_iter) begin
      r_a   <= w_a_nx;
      r_b   <= w_b_nx;
      r_p   <= r_p + w_term;
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_a   <= r_a;
      r_b   <= r_b;
      r_p   <= r_p;
      r_cnt <= r_cnt;
    end
  end

  // Result registers: loaded once in SUM, held stable through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res  <= {SIZE{1'b0}};
      r_exp1 <= 1'b0;
    end else if (w_do_sum) begin
      r_res  <= w_res_nx;
      r_exp1 <= w_exp1_nx;
    end else begin
      r_res  <= r_res;
      r_exp1 <= r_exp1;
    end
  end

endmodule

// File: tb/tb_plam_seq.sv
// tb_plam_seq: self-checking bench for plam_seq (SIZE=16, ITER=2).
// Reference model: P = X1*X2 - Ar*Br, where Ar/Br are the operands with
// up to ITER leading ones stripped (stopping once either reaches zero).
module tb_plam_seq;

  localparam int SIZE = 16;
  localparam int ITER = 2;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  plam_seq_if #(.SIZE(SIZE)) bus ();

  plam_seq #(.SIZE(SIZE), .ITER(ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic longint msb_val(input longint v);
    longint m;
    m = 1;
    while (m * 2 <= v) m = m * 2;
    return m;
  endfunction

  task automatic model(input logic [15:0] x1, input logic [15:0] x2,
                       output logic [15:0] r, output logic e);
    longint a, b, p, s, t;
    a = longint'(x1);
    b = longint'(x2);
    for (int i = 0; i < ITER; i++) begin
      if (a != 0 && b != 0) begin
        a = a - msb_val(a);
        b = b - msb_val(b);
      end
    end
    p = longint'(x1) * longint'(x2) - a * b;
    s = 65536 + longint'(x1) + longint'(x2) + (p >> 16);
    if (s >= 131072) begin
      e = 1'b1;
      t = (s >> 1) & 65535;
`ifdef PLAM_ROUND_EN
      t = t + (s & 1);
      if (t > 65535) t = 65535;
`endif
    end else begin
      e = 1'b0;
      t = s & 65535;
    end
    r = t[15:0];
  endtask

  // Full transaction: accept, count latency, hold in DONE for 'hold' cycles, consume.
  task automatic run_op(input logic [15:0] x1, input logic [15:0] x2, input int hold);
    logic [15:0] er;
    logic        ee;
    int          wt;
    int          lat;
    model(x1, x2, er, ee);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.X1        = x1;
    bus.X2        = x2;
    bus.out_ready = (hold == 0);
    wt = 0;
    while (!bus.in_ready && wt < 50) begin
      @(negedge clk);
      wt++;
    end
    chk("accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.X1 = 16'($urandom);
    bus.X2 = 16'($urandom);
    @(negedge clk);
    chk("busy_after_accept", 32'(bus.in_ready), 32'd0);
    chk("no_early_valid", 32'(bus.out_valid), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      chk("in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    chk("latency", 32'(lat), 32'(ITER + 1));
    chk("res", 32'(bus.res), 32'(er));
    chk("exp1", 32'(bus.exp1), 32'(ee));
    bus.in_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_res", 32'(bus.res), 32'(er));
      chk("hold_exp1", 32'(bus.exp1), 32'(ee));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("consumed_valid", 32'(bus.out_valid), 32'd0);
    chk("ready_after_consume", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_vec         = 0;
    n_miss        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.X1        = 16'h0000;
    bus.X2        = 16'h0000;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_res", 32'(bus.res), 32'd0);
    chk("rst_exp1", 32'(bus.exp1), 32'd0);
    rst_n = 1'b1;

    // Directed cases from the worked examples.
    run_op(16'h0000, 16'h0000, 0);
    chk("dir_zero_res", 32'(bus.res), 32'h0000);
    run_op(16'h8000, 16'h8000, 0);
    chk("dir_2p25_res", 32'(bus.res), 32'h2000);
    run_op(16'hC000, 16'h4000, 1);
    chk("dir_c000_res", 32'(bus.res), 32'h1800);
    run_op(16'h8001, 16'h8000, 0);
`ifdef PLAM_ROUND_EN
    chk("dir_round_res", 32'(bus.res), 32'h2001);
`else
    chk("dir_trunc_res", 32'(bus.res), 32'h2000);
`endif
    run_op(16'h0001, 16'hFFFF, 2);
    run_op(16'hFFFF, 16'h0000, 0);
    run_op(16'hFFFF, 16'hFFFF, 10);
    chk("dir_ffff_res", 32'(bus.res), 32'hF7FE);
    chk("dir_ffff_exp1", 32'(bus.exp1), 32'd1);

    // Reset during ITER: abort immediately, result register cleared.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.X1 = 16'h1234;
    bus.X2 = 16'h5678;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_res", 32'(bus.res), 32'd0);
    chk("midrst_exp1", 32'(bus.exp1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_no_valid", 32'(bus.out_valid), 32'd0);

    // Randomized operands, including sparse and dense bit patterns.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] x1;
      logic [15:0] x2;
      x1 = 16'($urandom);
      x2 = 16'($urandom);
      if (n % 4 == 1) x1 = x1 & 16'($urandom);
      if (n % 4 == 2) x2 = x2 | 16'hFF00;
      if (n % 8 == 3) x1 = 16'h0000;
      run_op(x1, x2, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
